// File: rtl/reverb_template_s2m_fifo_pkg.sv
// Shared constants and types for the stream-to-memory-mapped FIFO.
// Optional status register selected by macro REVERB_S2M_FIFO_STATUS_EN.
package reverb_template_s2m_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int PTR_W      = $clog2(DEPTH_DEF);
  localparam int CNT_W      = PTR_W + 1;

  // Status word bit positions
  localparam int EMPTY_BIT  = 31;
  localparam int FULL_BIT   = 30;

  // Read-slave register map
  typedef enum logic {
    ADDR_DATA   = 1'b0,
    ADDR_STATUS = 1'b1
  } reg_addr_e;

endpackage

// File: rtl/reverb_template_s2m_fifo_mem.sv
// FIFO storage: one write port, one synchronous read port, no reset.
module reverb_template_s2m_fifo_mem
  import reverb_template_s2m_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = PTR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
  end

  // Synchronous read port; q holds between reads
  always_ff @(posedge clock) begin
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/reverb_template_s2m_fifo.sv
// Avalon-ST sink into a circular FIFO, drained through an Avalon-MM read
// slave (address 0 = data pop, address 1 = status). Fixed read latency 1.
// Macro REVERB_S2M_FIFO_STATUS_EN enables the status word
// {empty, full, zeros, cnt}; otherwise status reads return zero.
module reverb_template_s2m_fifo
  import reverb_template_s2m_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  input  logic              avalonst_sink_valid,
  output logic              avalonst_sink_ready,
  input  logic              avalonmm_read_slave_address,
  input  logic              avalonmm_read_slave_read,
  output logic [DATA_W-1:0] avalonmm_read_slave_readdata,
  output logic              avalonmm_read_slave_readdatavalid,
  output logic              avalonmm_read_slave_waitrequest
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;
  logic              status_rd;
  logic              src_mem;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] status_q;
  reg_addr_e         addr;

  assign addr      = reg_addr_e'(avalonmm_read_slave_address);
  assign avalonst_sink_ready = reset_n & (cnt != FULL_CNT);
  assign push      = avalonst_sink_valid & avalonst_sink_ready;
  assign pop       = avalonmm_read_slave_read & (addr == ADDR_DATA) & (cnt != '0);
  assign status_rd = avalonmm_read_slave_read & (addr == ADDR_STATUS);
  assign avalonmm_read_slave_waitrequest =
    ~reset_n | (avalonmm_read_slave_read & (addr == ADDR_DATA) & (cnt == '0));

  reverb_template_s2m_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .wa    (wp),
    .wd    (avalonst_sink_data),
    .re    (pop),
    .ra    (rp),
    .q     (mem_q)
  );

  // Status word assembled from the registered count
  always_comb begin
    status_word = '0;
`ifdef REVERB_S2M_FIFO_STATUS_EN
    status_word[CW-1:0]    = cnt;
    status_word[EMPTY_BIT] = (cnt == '0);
    status_word[FULL_BIT]  = (cnt == FULL_CNT);
`endif
  end

  // Pointers, occupancy and read response tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      src_mem  <= 1'b0;
      status_q <= '0;
      avalonmm_read_slave_readdatavalid <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      avalonmm_read_slave_readdatavalid <= pop | status_rd;
      if (pop) begin
        src_mem <= 1'b1;
      end else if (status_rd) begin
        src_mem  <= 1'b0;
        status_q <= status_word;
      end
    end
  end

  // The memory read register cannot be reset, so readdata is the registered
  // mem output or a resettable status register, chosen by the last read kind;
  // src_mem clears on reset so readdata reads 0 until the next read.
  assign avalonmm_read_slave_readdata = src_mem ? mem_q : status_q;

endmodule

// File: tb/tb_reverb_template_s2m_fifo.sv
// Self-checking bench for reverb_template_s2m_fifo (DATA_W 32, DEPTH 32).
// Expectations come from a queue-based model of the FIFO behaviour.
module tb_reverb_template_s2m_fifo;

  localparam int DW = 32;
  localparam int DP = 32;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] sink_data;
  logic          sink_valid;
  logic          sink_ready;
  logic          mm_address;
  logic          mm_read;
  logic [DW-1:0] mm_readdata;
  logic          mm_readdatavalid;
  logic          mm_waitrequest;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_rd;

  reverb_template_s2m_fifo #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clock                             (clock),
    .reset_n                           (reset_n),
    .avalonst_sink_data                (sink_data),
    .avalonst_sink_valid               (sink_valid),
    .avalonst_sink_ready               (sink_ready),
    .avalonmm_read_slave_address       (mm_address),
    .avalonmm_read_slave_read          (mm_read),
    .avalonmm_read_slave_readdata      (mm_readdata),
    .avalonmm_read_slave_readdatavalid (mm_readdatavalid),
    .avalonmm_read_slave_waitrequest   (mm_waitrequest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] status_of(input int unsigned n);
    logic [DW-1:0] w;
    w = '0;
`ifdef REVERB_S2M_FIFO_STATUS_EN
    w = DW'(n);
    w[31] = (n == 0);
    w[30] = (n == DP);
`endif
    return w;
  endfunction

  // One clock cycle; entered and left at posedge + 1.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic rd, input logic addr);
    logic          do_push;
    logic          do_pop;
    logic          exp_rdv;
    int unsigned   n;
    sink_valid = v;
    sink_data  = d;
    mm_read    = rd;
    mm_address = addr;
    #3;
    n = model_q.size();
    check({tag, "/ready"}, DW'(sink_ready), DW'(n != DP));
    check({tag, "/wait"}, DW'(mm_waitrequest), DW'(rd && !addr && n == 0));
    do_push = v && (n != DP);
    do_pop  = rd && !addr && (n != 0);
    exp_rdv = rd && (addr || n != 0);
    if (do_pop) last_rd = model_q.pop_front();
    else if (rd && addr) last_rd = status_of(n);
    if (do_push) model_q.push_back(d);
    @(posedge clock);
    #1;
    check({tag, "/rdv"}, DW'(mm_readdatavalid), DW'(exp_rdv));
    check({tag, "/rdata"}, mm_readdata, last_rd);
    sink_valid = 1'b0;
    mm_read    = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    reset_n = 1'b0; sink_valid = 1'b0; sink_data = '0;
    mm_read = 1'b1; mm_address = 1'b0;
    model_q.delete();
    last_rd = '0;
    @(posedge clock); @(posedge clock); #1;
    check("rst/ready", DW'(sink_ready), '0);
    check("rst/wait", DW'(mm_waitrequest), DW'(1));
    check("rst/rdv", DW'(mm_readdatavalid), '0);
    check("rst/rdata", mm_readdata, '0);
    mm_read = 1'b0;
    reset_n = 1'b1;
    cycle("idle", 1'b0, '0, 1'b0, 1'b0);

    // Three words in, three data reads out
    cycle("p11", 1'b1, 32'h11, 1'b0, 1'b0);
    cycle("p22", 1'b1, 32'h22, 1'b0, 1'b0);
    cycle("p33", 1'b1, 32'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("rd3", 1'b0, '0, 1'b1, 1'b0);
    cycle("gap", 1'b0, '0, 1'b0, 1'b0);

    // Fill to full, overflow word ignored, drain in order
    for (int i = 0; i < DP; i++) cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    cycle("ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < DP; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    cycle("drain_empty", 1'b0, '0, 1'b1, 1'b0);

    // Read stalls on empty until a word is pushed
    cycle("stall", 1'b0, '0, 1'b1, 1'b0);
    cycle("stall", 1'b0, '0, 1'b1, 1'b0);
    cycle("stall_push", 1'b1, 32'hABCD, 1'b1, 1'b0);
    cycle("stall_pop", 1'b0, '0, 1'b1, 1'b0);

    // Full FIFO with push and pop presented together
    for (int i = 0; i < DP; i++) cycle("fill2", 1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    cycle("full_pp", 1'b1, 32'h55, 1'b1, 1'b0);
    cycle("full_p", 1'b1, 32'h55, 1'b0, 1'b0);
    cycle("full_hold", 1'b1, 32'h66, 1'b0, 1'b0);
    cycle("full_stat", 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < DP; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);
    check("drain2/last55", last_rd, 32'h55);

    // Random push/pop across pointer wrap
    for (int i = 0; i < 20; i++) cycle("pre", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      cycle("rand", 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0));
    end
    while (model_q.size() != 0) cycle("rdrain", 1'b0, '0, 1'b1, 1'b0);

    // Status register with 5 words, then empty
    for (int i = 0; i < 5; i++) cycle("p5", 1'b1, DW'(i + 7), 1'b0, 1'b0);
    cycle("stat5", 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("d5", 1'b0, '0, 1'b1, 1'b0);
    cycle("stat0", 1'b0, '0, 1'b1, 1'b1);

    // Reset with 10 words buffered and a read in flight
    for (int i = 0; i < 10; i++) cycle("p10", 1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
    mm_read = 1'b1; mm_address = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst/rdv", DW'(mm_readdatavalid), '0);
    check("mid_rst/rdata", mm_readdata, '0);
    @(posedge clock); @(posedge clock); #1;
    check("mid_rst/rdv2", DW'(mm_readdatavalid), '0);
    mm_read = 1'b0;
    reset_n = 1'b1;
    model_q.delete();
    last_rd = '0;
    cycle("post_rst", 1'b0, '0, 1'b0, 1'b0);
    cycle("post_rst", 1'b0, '0, 1'b0, 1'b0);
    cycle("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("post_rst_stat", 1'b0, '0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
